mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader_pkg.sv | 15 +
 rtl/byte_packer.sv | 38 +++
 rtl/mem_loader.sv | 120 ++++++++++++
 tb/tb_mem_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// rtl/mem_loader_pkg.sv - state encoding and word-geometry helper for mem_loader
// Defining MEM_LOADER_CHECKSUM_EN adds the CHECK state for the trailing checksum byte.
package mem_loader_pkg;

`ifdef MEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_CHECK, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;
`endif

  function automatic int bytes_per_word(input int bw);
    return bw / 8;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - little-endian byte-to-word assembler with lane counter
module byte_packer
  import mem_loader_pkg::*;
#(
  parameter int BW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load,
  input  logic [7:0]    data,
  output logic [BW-1:0] word,
  output logic          last_lane
);

  localparam int BPW = bytes_per_word(BW);
  localparam int LW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [LW-1:0] lane;

  assign last_lane = (lane == LW'(BPW - 1));

  // Lane k of a word lands in bits [8k+7:8k], so the first byte is the LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane <= '0;
      word <= '0;
    end else if (clear) begin
      lane <= '0;
    end else if (load) begin
      lane <= last_lane ? '0 : lane + 1'b1;
      for (int k = 0; k < BPW; k++) begin
        if (lane == LW'(k)) word[8*k +: 8] <= data;
      end
    end
  end

endmodule

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - byte stream to word memory loader; MEM_LOADER_CHECKSUM_EN enables
// a trailing 8-bit modular checksum byte and the err flag.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int BW = 32,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW:0]   len,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          wr_en,
  output logic [DW-1:0] wr_addr,
  output logic [BW-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t        state, state_nx;
  logic [DW-1:0] addr;
  logic [DW:0]   len_q, count, len_sat;
  logic          accept_start, collect_hs, last_word, lane_last;

  // Any count with the top bit set is at least 2**DW, so it saturates to exactly 2**DW.
  assign len_sat      = len[DW] ? {1'b1, {DW{1'b0}}} : len;
  assign accept_start = start && (state == S_IDLE);
  assign collect_hs   = s_valid && s_ready && (state == S_COLLECT);
  assign last_word    = ((count + 1'b1) == len_q);
  assign busy         = (state != S_IDLE);
  assign wr_addr      = addr;

  byte_packer #(.BW(BW)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept_start),
    .load      (collect_hs),
    .data      (s_data),
    .word      (wr_data),
    .last_lane (lane_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    s_ready  = 1'b0;
    wr_en    = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE:    if (start) state_nx = (len == '0) ? S_DONE : S_COLLECT;
      S_COLLECT: begin
        s_ready = 1'b1;
        if (s_valid && lane_last) state_nx = S_WRITE;
      end
      S_WRITE: begin
        wr_en = 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
        state_nx = last_word ? S_CHECK : S_COLLECT;
`else
        state_nx = last_word ? S_DONE : S_COLLECT;
`endif
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        s_ready = 1'b1;
        if (s_valid) state_nx = S_DONE;
      end
`endif
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // The address stops advancing on the final word, so a 2**DW load never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr  <= '0;
      count <= '0;
      len_q <= '0;
    end else if (accept_start) begin
      addr  <= '0;
      count <= '0;
      len_q <= len_sat;
    end else if (state == S_WRITE) begin
      count <= count + 1'b1;
      if (!last_word) addr <= addr + 1'b1;
    end
  end

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0] sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
      err <= 1'b0;
    end else if (accept_start) begin
      sum <= '0;
      err <= 1'b0;
    end else begin
      if (collect_hs) sum <= sum + s_data;
      if (s_valid && s_ready && (state == S_CHECK)) err <= (s_data != sum);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - randomized self-checking bench for mem_loader (BW=32, DW=8)
module tb_mem_loader;
  localparam int BW = 32;
  localparam int DW = 8;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [DW-1:0] a;
    logic [BW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW:0]   len = '0;
  logic [7:0]    s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready, wr_en, busy, done, err;
  logic [DW-1:0] wr_addr;
  logic [BW-1:0] wr_data;

  int  tests_run = 0;
  int  tests_failed = 0;
  wr_t wq[$];
  int  done_cnt = 0;

  mem_loader #(.BW(BW), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .len     (len),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        wr_t w;
        w.a = wr_addr;
        w.d = wr_data;
        wq.push_back(w);
      end
      if (done) done_cnt++;
    end
  end

  function automatic logic [BW-1:0] model_word(input bq_t b, input int i);
    return {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
  endfunction

  function automatic logic [7:0] model_sum(input bq_t b);
    int s = 0;
    foreach (b[i]) s += int'(b[i]);
    return 8'(s % 256);
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(255)));
    return q;
  endfunction

  task automatic do_start(input int n);
    @(negedge clk);
    start = 1'b1;
    len   = n[DW:0];
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bytes(input bq_t q, input int gap_pct, input int mid_at, output bit ok);
    int idx = 0;
    int budget = 0;
    bit hs;
    while (idx < q.size() && budget < 20000) begin
      s_valid = ($urandom_range(99) >= gap_pct);
      s_data  = q[idx];
      start   = (idx == mid_at);
      if (idx == mid_at) len = 9'd5;
      hs = s_valid && s_ready;
      @(negedge clk);
      if (hs) idx++;
      budget++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    ok = (idx == q.size());
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = !busy;
  endtask

  task automatic run_load(input int n, input bq_t data, input int gap_pct, input int mid_at, output bit ok);
    bq_t tx = data;
    bit  ok1, ok2;
`ifdef MEM_LOADER_CHECKSUM_EN
    tx.push_back(model_sum(data));
`endif
    do_start(n);
    ok1 = 1'b1;
    if (n != 0) send_bytes(tx, gap_pct, mid_at, ok1);
    wait_idle(ok2);
    ok = ok1 && ok2;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests_run++; if (s_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
    tests_run++; if (wr_en !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    tests_run++; if (wr_addr !== '0) begin tests_failed++; $display("FAIL reset_wr_addr got %h want 0", wr_addr); end
    tests_run++; if (wr_data !== '0) begin tests_failed++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b want 0", err); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    bq_t b = '{8'h11, 8'h22, 8'h33, 8'h44};
    wq.delete();
    do_start(1);
    for (int k = 0; k < 4; k++) begin
      s_valid = 1'b1;
      s_data  = b[k];
      @(negedge clk);
    end
    s_valid = 1'b0;
    tests_run++; if (wr_en !== 1'b1) begin tests_failed++; $display("FAIL single_wr_en got %b want 1", wr_en); end
    tests_run++; if (wr_addr !== 8'h00) begin tests_failed++; $display("FAIL single_addr got %h want 00", wr_addr); end
    tests_run++; if (wr_data !== 32'h44332211) begin tests_failed++; $display("FAIL single_data got %h want 44332211", wr_data); end
    @(negedge clk);
`ifdef MEM_LOADER_CHECKSUM_EN
    tests_run++; if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL single_check_ready got %b want 1", s_ready); end
    s_valid = 1'b1;
    s_data  = 8'hAA;
    @(negedge clk);
    s_valid = 1'b0;
`endif
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL single_done got %b want 1", done); end
    tests_run++; if (wr_en !== 1'b0) begin tests_failed++; $display("FAIL single_wr_once got %b want 0", wr_en); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL single_err got %b want 0", err); end
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_idle got busy=%b want 0", busy); end
    tests_run++; if (wq.size() != 1) begin tests_failed++; $display("FAIL single_count got %0d want 1", wq.size()); end
  endtask

  task automatic test_gaps;
    bq_t b = rand_bytes(12);
    int  d0 = done_cnt;
    bit  ok;
    wq.delete();
    run_load(3, b, 40, 5, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL gaps_timeout got stalled want complete"); end
    tests_run++; if (wq.size() != 3) begin tests_failed++; $display("FAIL gaps_count got %0d want 3", wq.size()); end
    for (int i = 0; i < 3 && i < wq.size(); i++) begin
      tests_run++; if (wq[i].a !== i[DW-1:0] || wq[i].d !== model_word(b, i)) begin
        tests_failed++; $display("FAIL gaps_word%0d got %h@%h want %h@%h", i, wq[i].d, wq[i].a, model_word(b, i), i[DW-1:0]);
      end
    end
    tests_run++; if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL gaps_done got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_zero;
    int d0 = done_cnt;
    wq.delete();
    do_start(0);
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL zero_done got %b want 1", done); end
    tests_run++; if (s_ready !== 1'b0) begin tests_failed++; $display("FAIL zero_ready got %b want 0", s_ready); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL zero_busy got %b want 1", busy); end
    @(negedge clk);
    tests_run++; if (done !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL zero_after got done=%b busy=%b want 0 0", done, busy); end
    tests_run++; if (wq.size() != 0 || done_cnt - d0 != 1) begin
      tests_failed++; $display("FAIL zero_events got writes=%0d dones=%0d want 0 1", wq.size(), done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid;
    bq_t b = rand_bytes(4);
    int  d0 = done_cnt;
    bit  ok;
    wq.delete();
    do_start(2);
    for (int k = 0; k < 2; k++) begin
      s_valid = 1'b1;
      s_data  = 8'hA5;
      @(negedge clk);
    end
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    tests_run++; if ({s_ready, wr_en, busy, done, err} !== 5'b0) begin
      tests_failed++; $display("FAIL rstmid_flags got %b want 00000", {s_ready, wr_en, busy, done, err});
    end
    tests_run++; if (wr_addr !== '0 || wr_data !== '0) begin tests_failed++; $display("FAIL rstmid_bus got %h/%h want 0/0", wr_addr, wr_data); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++; if (wq.size() != 0 || done_cnt != d0) begin
      tests_failed++; $display("FAIL rstmid_events got writes=%0d dones=%0d want 0 0", wq.size(), done_cnt - d0);
    end
    run_load(1, b, 20, -1, ok);
    tests_run++; if (!ok || wq.size() != 1) begin tests_failed++; $display("FAIL rstmid_reload got ok=%b writes=%0d want 1 1", ok, wq.size()); end
    else begin
      tests_run++; if (wq[0].a !== 8'h00 || wq[0].d !== model_word(b, 0)) begin
        tests_failed++; $display("FAIL rstmid_word got %h@%h want %h@00", wq[0].d, wq[0].a, model_word(b, 0));
      end
    end
  endtask

  task automatic test_full(input int n);
    int  nw = (n > 256) ? 256 : n;
    bq_t b = rand_bytes(4 * nw);
    int  d0 = done_cnt;
    int  bad = 0;
    bit  ok;
    wq.delete();
    run_load(n, b, 10, -1, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL full%0d_timeout got stalled want complete", n); end
    tests_run++; if (wq.size() != nw) begin tests_failed++; $display("FAIL full%0d_count got %0d want %0d", n, wq.size(), nw); end
    for (int i = 0; i < wq.size() && i < nw; i++)
      if (wq[i].a !== i[DW-1:0] || wq[i].d !== model_word(b, i)) bad++;
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL full%0d_words got %0d bad want 0", n, bad); end
    tests_run++; if (wq.size() == 0 || wq[wq.size()-1].a !== 8'hFF) begin tests_failed++; $display("FAIL full%0d_last_addr want ff", n); end
    tests_run++; if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL full%0d_done got %0d want 1", n, done_cnt - d0); end
  endtask

`ifdef MEM_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    bq_t good = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    bq_t bad  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
    int  d0;
    bit  ok1, ok2;
    d0 = done_cnt;
    do_start(1); send_bytes(good, 30, -1, ok1); wait_idle(ok2);
    tests_run++; if (!(ok1 && ok2) || err !== 1'b0) begin tests_failed++; $display("FAIL chk_good got err=%b want 0", err); end
    tests_run++; if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL chk_good_done got %0d want 1", done_cnt - d0); end
    d0 = done_cnt;
    do_start(1); send_bytes(bad, 30, -1, ok1); wait_idle(ok2);
    tests_run++; if (!(ok1 && ok2) || err !== 1'b1) begin tests_failed++; $display("FAIL chk_bad got err=%b want 1", err); end
    tests_run++; if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL chk_bad_done got %0d want 1", done_cnt - d0); end
    repeat (3) @(negedge clk);
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL chk_hold got err=%b want 1", err); end
    do_start(0);
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL chk_clear got err=%b want 0", err); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_gaps();
    test_zero();
    test_reset_mid();
    test_full(256);
    test_full(300);
`ifdef MEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
